// File: rtl/metronome_tempo_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : metronome_tempo_ctrl                                          |
// | Description : BPM register with preset/tap control, sequential period       |
// |               divider, BCD conversion and 14-step LED sweep with click.     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module metronome_tempo_ctrl #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEFAULT_BPM  = 60,
    parameter int MIN_BPM      = 40,
    parameter int MAX_BPM      = 240,
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int CLICK_CYC    = 250_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] preset_sel,
    input  logic       tap_up_n,
    input  logic       tap_down_n,
    output logic [7:0] bpm,
    output logic [3:0] dig100,
    output logic [3:0] dig10,
    output logic [3:0] dig1,
    output logic [7:0] led,
    output logic       click,
    output logic       beat_tick,
    output logic       busy
);

    localparam logic [63:0] c_dividend_wide = 64'(CLK_HZ) * 64'd60;
    localparam logic [31:0] c_dividend      = c_dividend_wide[31:0];
    localparam logic [7:0]  c_def_bpm       = 8'(DEFAULT_BPM);
    localparam logic [7:0]  c_min_bpm       = 8'(MIN_BPM);
    localparam logic [7:0]  c_max_bpm       = 8'(MAX_BPM);
    localparam logic [31:0] c_deb_last      = 32'(DEBOUNCE_CYC - 1);
    localparam logic [31:0] c_click_last    = 32'(CLICK_CYC - 1);
    localparam logic [3:0]  c_def_d100      = 4'(DEFAULT_BPM / 100);
    localparam logic [3:0]  c_def_d10       = 4'((DEFAULT_BPM / 10) % 10);
    localparam logic [3:0]  c_def_d1        = 4'(DEFAULT_BPM % 10);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_div_init = 2'd1;
    localparam logic [1:0] c_st_div      = 2'd2;
    localparam logic [1:0] c_st_bcd      = 2'd3;

    logic [1:0] w_key_raw;
    logic [1:0] w_key_fall;
    assign w_key_raw = {tap_down_n, tap_up_n};

    for (genvar k = 0; k < 2; k++) begin : g_key
        logic        r_s1, r_s2, r_db;
        logic [31:0] r_cnt;
        always_ff @(posedge clock) begin
            if (!reset) begin
                r_s1  <= 1'b1;
                r_s2  <= 1'b1;
                r_db  <= 1'b1;
                r_cnt <= '0;
            end else begin
                r_s1 <= w_key_raw[k];
                r_s2 <= r_s1;
                if (r_s2 == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_deb_last) begin
                    r_db  <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
        end
        assign w_key_fall[k] = (r_s2 != r_db) && (r_cnt == c_deb_last) && !r_s2;
    end

    logic [4:0]  r_sel, r_sel_d;
    logic [7:0]  r_bpm, r_bin;
    logic        r_pending, r_busy, r_shadow_valid;
    logic [1:0]  r_state;
    logic [4:0]  r_bit_cnt;
    logic [31:0] r_quot, r_shadow;
    logic [11:0] r_rem, r_divisor;
    logic [11:0] r_bcd;
    logic [3:0]  r_d100, r_d10, r_d1;
    logic        w_sel_chg;
    logic [7:0]  w_preset_raw, w_preset, w_bpm_next;
    logic [12:0] w_rem_shift, w_rem_sub;
    logic        w_rem_ge;
    logic [11:0] w_bcd_adj, w_bcd_next;
    logic [31:0] w_quot_final;

    assign w_sel_chg = (r_sel != r_sel_d);

    always_comb begin
        w_preset_raw = (r_sel > 5'd17) ? 8'd230 : 8'd60 + 8'(r_sel) * 8'd10;
        if (w_preset_raw < c_min_bpm)      w_preset = c_min_bpm;
        else if (w_preset_raw > c_max_bpm) w_preset = c_max_bpm;
        else                               w_preset = w_preset_raw;
    end

    // Preset load has priority; simultaneous up+down presses cancel out.
    always_comb begin
        w_bpm_next = r_bpm;
        if (w_sel_chg)
            w_bpm_next = w_preset;
        else if (w_key_fall == 2'b01)
            w_bpm_next = (r_bpm >= c_max_bpm) ? r_bpm : r_bpm + 8'd1;
        else if (w_key_fall == 2'b10)
            w_bpm_next = (r_bpm <= c_min_bpm) ? r_bpm : r_bpm - 8'd1;
    end

    assign w_rem_shift  = {r_rem, r_quot[31]};
    assign w_rem_ge     = (w_rem_shift >= {1'b0, r_divisor});
    assign w_rem_sub    = w_rem_shift - {1'b0, r_divisor};
    assign w_quot_final = (r_quot == 32'd0) ? 32'd1 : r_quot;

    always_comb begin
        w_bcd_adj = r_bcd;
        if (r_bcd[3:0]  >= 4'd5) w_bcd_adj[3:0]  = r_bcd[3:0]  + 4'd3;
        if (r_bcd[7:4]  >= 4'd5) w_bcd_adj[7:4]  = r_bcd[7:4]  + 4'd3;
        if (r_bcd[11:8] >= 4'd5) w_bcd_adj[11:8] = r_bcd[11:8] + 4'd3;
        w_bcd_next = {w_bcd_adj[10:0], r_bin[7]};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sel          <= '0;
            r_sel_d        <= '0;
            r_bpm          <= c_def_bpm;
            r_pending      <= 1'b0;
            r_state        <= c_st_div_init;
            r_busy         <= 1'b1;
            r_bit_cnt      <= '0;
            r_quot         <= '0;
            r_rem          <= '0;
            r_divisor      <= '0;
            r_bin          <= '0;
            r_bcd          <= '0;
            r_d100         <= c_def_d100;
            r_d10          <= c_def_d10;
            r_d1           <= c_def_d1;
            r_shadow       <= '0;
            r_shadow_valid <= 1'b0;
        end else begin
            r_sel     <= preset_sel;
            r_sel_d   <= r_sel;
            r_bpm     <= w_bpm_next;
            r_pending <= (w_bpm_next != r_bpm) || (r_pending && (r_state != c_st_idle));
            case (r_state)
                c_st_idle: begin
                    if (r_pending) begin
                        r_state <= c_st_div_init;
                        r_busy  <= 1'b1;
                    end
                end
                c_st_div_init: begin
                    r_quot    <= c_dividend;
                    r_rem     <= '0;
                    r_divisor <= 12'(r_bpm) * 12'd14;
                    r_bin     <= r_bpm;
                    r_bcd     <= '0;
                    r_bit_cnt <= '0;
                    r_state   <= c_st_div;
                end
                c_st_div: begin
                    r_rem  <= w_rem_ge ? w_rem_sub[11:0] : w_rem_shift[11:0];
                    r_quot <= {r_quot[30:0], w_rem_ge};
                    if (r_bit_cnt == 5'd31) begin
                        r_bit_cnt <= '0;
                        r_state   <= c_st_bcd;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
                c_st_bcd: begin
                    r_bcd <= w_bcd_next;
                    r_bin <= {r_bin[6:0], 1'b0};
                    if (r_bit_cnt == 5'd7) begin
                        r_d100         <= w_bcd_next[11:8];
                        r_d10          <= w_bcd_next[7:4];
                        r_d1           <= w_bcd_next[3:0];
                        r_shadow       <= w_quot_final;
                        r_shadow_valid <= 1'b1;
                        r_state        <= c_st_idle;
                        r_busy         <= 1'b0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    function automatic logic [7:0] f_led(input logic [3:0] p);
        logic [7:0] v;
        v = 8'd0;
        if (p < 4'd8) v = 8'd1 << p;
        else          v = 8'd1 << (4'd14 - p);
        return v;
    endfunction

    logic        r_running, r_click, r_beat;
    logic [31:0] r_period, r_step_cnt, r_click_left;
    logic [3:0]  r_pos;
    logic [7:0]  r_led;
    logic        w_wrap;
    logic [3:0]  w_pos_next;

    assign w_wrap     = r_running && (r_step_cnt == r_period - 32'd1);
    assign w_pos_next = (r_pos == 4'd13) ? 4'd0 : r_pos + 4'd1;

    // The shadow period is only adopted at a wrap so a step never changes length mid-count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_running    <= 1'b0;
            r_period     <= '0;
            r_step_cnt   <= '0;
            r_pos        <= '0;
            r_led        <= 8'h01;
            r_click      <= 1'b0;
            r_click_left <= '0;
            r_beat       <= 1'b0;
        end else begin
            r_beat <= 1'b0;
            if (!r_running) begin
                if (r_shadow_valid) begin
                    r_running  <= 1'b1;
                    r_period   <= r_shadow;
                    r_step_cnt <= '0;
                end
            end else if (w_wrap) begin
                r_step_cnt <= '0;
                r_period   <= r_shadow;
                r_pos      <= w_pos_next;
                r_led      <= f_led(w_pos_next);
                r_beat     <= (w_pos_next == 4'd0);
            end else begin
                r_step_cnt <= r_step_cnt + 32'd1;
            end

            if (w_wrap) begin
                if (w_pos_next == 4'd0 || w_pos_next == 4'd7) begin
                    r_click      <= 1'b1;
                    r_click_left <= c_click_last;
                end else begin
                    r_click      <= 1'b0;
                    r_click_left <= '0;
                end
            end else if (r_click_left != 32'd0) begin
                r_click_left <= r_click_left - 32'd1;
            end else begin
                r_click <= 1'b0;
            end
        end
    end

    assign bpm       = r_bpm;
    assign dig100    = r_d100;
    assign dig10     = r_d10;
    assign dig1      = r_d1;
    assign led       = r_led;
    assign click     = r_click;
    assign beat_tick = r_beat;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_metronome_tempo_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_metronome_tempo_ctrl                                       |
// | Description : Self-checking bench for metronome_tempo_ctrl.                 |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_metronome_tempo_ctrl;

    localparam int CLK_HZ    = 1400;
    localparam int DEB       = 4;
    localparam int CLICK_CYC = 3;
    localparam int MIN_BPM   = 40;
    localparam int MAX_BPM   = 240;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] preset_sel = 5'd0;
    logic       tap_up_n = 1'b1;
    logic       tap_down_n = 1'b1;
    logic [7:0] bpm, led;
    logic [3:0] dig100, dig10, dig1;
    logic       click, beat_tick, busy;

    metronome_tempo_ctrl #(
        .CLK_HZ(CLK_HZ), .DEFAULT_BPM(60), .MIN_BPM(MIN_BPM), .MAX_BPM(MAX_BPM),
        .DEBOUNCE_CYC(DEB), .CLICK_CYC(CLICK_CYC)
    ) dut (
        .clock(clock), .reset(reset), .preset_sel(preset_sel),
        .tap_up_n(tap_up_n), .tap_down_n(tap_down_n), .bpm(bpm),
        .dig100(dig100), .dig10(dig10), .dig1(dig1), .led(led),
        .click(click), .beat_tick(beat_tick), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int m_bpm = 60;
    int m_sel = 0;

    typedef struct {
        int sel;
        int bpm;
        int d100;
        int d10;
        int d1;
        int period;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int preset_bpm(input int sel);
        int b;
        b = (sel > 17) ? 230 : 60 + 10 * sel;
        if (b < MIN_BPM) b = MIN_BPM;
        if (b > MAX_BPM) b = MAX_BPM;
        return b;
    endfunction

    function automatic int period_of(input int b);
        int q;
        q = (CLK_HZ * 60) / (b * 14);
        return (q == 0) ? 1 : q;
    endfunction

    function automatic int led_of(input int p);
        return (p < 8) ? (1 << p) : (1 << (14 - p));
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk({name, " busy"}, int'(busy), 0);
    endtask

    task automatic chk_model(input string name);
        chk({name, " bpm"}, int'(bpm), m_bpm);
        chk({name, " dig100"}, int'(dig100), m_bpm / 100);
        chk({name, " dig10"}, int'(dig10), (m_bpm / 10) % 10);
        chk({name, " dig1"}, int'(dig1), m_bpm % 10);
    endtask

    task automatic set_sel(input int sel);
        preset_sel = 5'(sel);
        if (sel != m_sel) begin
            m_sel = sel;
            m_bpm = preset_bpm(sel);
        end
        repeat (4) @(negedge clock);
        wait_idle("preset");
    endtask

    task automatic press(input bit up, input bit dn, input int hold);
        tap_up_n   = ~up;
        tap_down_n = ~dn;
        repeat (hold) @(negedge clock);
        tap_up_n   = 1'b1;
        tap_down_n = 1'b1;
        repeat (12) @(negedge clock);
        if (hold > DEB + 2) begin
            if (up && !dn)      m_bpm = (m_bpm >= MAX_BPM) ? m_bpm : m_bpm + 1;
            else if (dn && !up) m_bpm = (m_bpm <= MIN_BPM) ? m_bpm : m_bpm - 1;
        end
    endtask

    task automatic wait_led_change(output int t);
        logic [7:0] prev;
        int n;
        prev = led;
        n = 0;
        @(negedge clock);
        while (led == prev && n < 1000) begin
            @(negedge clock);
            n++;
        end
        t = cyc;
    endtask

    task automatic measure_step(input string name, input int exp_len);
        int t1, t2;
        wait_led_change(t1);
        wait_led_change(t2);
        chk({name, " step length"}, t2 - t1, exp_len);
    endtask

    task automatic reset_window(input string name);
        int first_low;
        first_low = -1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clock);
            if (k == 40) chk({name, " busy at 40"}, int'(busy), 1);
            if (!busy && first_low < 0) first_low = k;
        end
        chk({name, " busy falls at 41..42"}, int'(first_low == 41 || first_low == 42), 1);
    endtask

    // Sweep monitor: each step started after the new quotient landed has new_len.
    task automatic watch(input int nsteps, input int old_len, input int new_len,
                         input int chg_step, input int chg_sel, output int lat);
        int pos, t_start, t_new, t_bpm, t_tick, clicks, k, n, exp_len, exp_clk;
        logic [7:0] prev_led, prev_bpm;
        logic prev_busy;
        pos = 0; k = 0; n = 0; t_new = 2147483647; t_bpm = 0;
        while (beat_tick !== 1'b1 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk("sync beat_tick", int'(beat_tick), 1);
        chk("led at beat", int'(led), 1);
        t_start = cyc; t_tick = cyc; prev_led = led; prev_busy = busy; prev_bpm = bpm;
        clicks = int'(click);
        exp_len = old_len;
        while (k < nsteps) begin
            @(negedge clock);
            if (prev_busy && !busy) t_new = cyc;
            if (bpm != prev_bpm) t_bpm = cyc;
            prev_busy = busy;
            prev_bpm  = bpm;
            exp_len = (t_start > t_new) ? new_len : old_len;
            if (led != prev_led) begin
                exp_clk = (pos == 0 || pos == 7) ? ((CLICK_CYC < exp_len) ? CLICK_CYC : exp_len) : 0;
                chk("step length", cyc - t_start, exp_len);
                chk("click width", clicks, exp_clk);
                pos = (pos + 1) % 14;
                chk("led", int'(led), led_of(pos));
                chk("beat_tick", int'(beat_tick), int'(pos == 0));
                if (pos == 0 && t_new == 2147483647) begin
                    chk("beat interval", cyc - t_tick, 14 * old_len);
                    t_tick = cyc;
                end
                t_start  = cyc;
                prev_led = led;
                clicks   = int'(click);
                k++;
                if (k == chg_step) preset_sel = 5'(chg_sel);
            end else begin
                if (beat_tick) chk("beat_tick width", 1, 0);
                clicks += int'(click);
                if (cyc - t_start > 2 * (old_len + new_len) + 20) begin
                    chk("step timeout", cyc - t_start, exp_len);
                    k = nsteps;
                end
            end
        end
        lat = t_new - t_bpm;
    endtask

    initial begin
        int lat, op, s;
        tbl[0] = '{sel: 9,  bpm: 150, d100: 1, d10: 5, d1: 0, period: 40};
        tbl[1] = '{sel: 1,  bpm: 70,  d100: 0, d10: 7, d1: 0, period: 85};
        tbl[2] = '{sel: 25, bpm: 230, d100: 2, d10: 3, d1: 0, period: 26};
        tbl[3] = '{sel: 0,  bpm: 60,  d100: 0, d10: 6, d1: 0, period: 100};
        tbl[4] = '{sel: 17, bpm: 230, d100: 2, d10: 3, d1: 0, period: 26};

        // Reset values and first recompute
        repeat (3) @(negedge clock);
        chk("reset bpm", int'(bpm), 60);
        chk("reset led", int'(led), 1);
        chk("reset click", int'(click), 0);
        chk("reset beat_tick", int'(beat_tick), 0);
        chk("reset busy", int'(busy), 1);
        chk_model("reset");
        reset = 1'b1;
        reset_window("startup");
        chk_model("startup");
        watch(15, 100, 100, -1, 0, lat);

        // Tempo change mid-sweep: current step keeps 100, later steps 50
        watch(6, 100, 50, 2, 6, lat);
        m_sel = 6;
        m_bpm = 120;
        chk("recompute latency", lat, 42);
        chk_model("sel6");

        // Preset table
        for (int i = 0; i < 5; i++) begin
            set_sel(tbl[i].sel);
            chk("table bpm", int'(bpm), tbl[i].bpm);
            chk("table dig100", int'(dig100), tbl[i].d100);
            chk("table dig10", int'(dig10), tbl[i].d10);
            chk("table dig1", int'(dig1), tbl[i].d1);
            measure_step("table", tbl[i].period);
        end

        // Upper clamp
        for (int i = 0; i < 12; i++) begin
            press(1'b1, 1'b0, 10);
            chk("tap up", int'(bpm), m_bpm);
        end
        chk("clamp max", int'(bpm), 240);
        wait_idle("max");
        chk_model("max");

        // Lower clamp
        set_sel(0);
        for (int i = 0; i < 21; i++) begin
            press(1'b0, 1'b1, 10);
            chk("tap down", int'(bpm), m_bpm);
        end
        chk("clamp min", int'(bpm), 40);
        wait_idle("min");
        chk_model("min");

        // Reset during the divide
        preset_sel = 5'd3;
        repeat (12) @(negedge clock);
        chk("busy before reset", int'(busy), 1);
        reset = 1'b0;
        preset_sel = 5'd0;
        repeat (2) @(negedge clock);
        m_sel = 0;
        m_bpm = 60;
        chk("midreset bpm", int'(bpm), 60);
        chk("midreset busy", int'(busy), 1);
        chk("midreset led", int'(led), 1);
        chk("midreset click", int'(click), 0);
        chk_model("midreset");
        reset = 1'b1;
        reset_window("rerun");
        chk_model("rerun");

        // Glitch and long hold
        tap_up_n = 1'b0;
        repeat (2) @(negedge clock);
        tap_up_n = 1'b1;
        repeat (20) @(negedge clock);
        chk("glitch ignored", int'(bpm), 60);
        press(1'b1, 1'b0, 1000);
        chk("long hold", int'(bpm), 61);
        wait_idle("hold");
        chk_model("hold");

        // Simultaneous keys, then preset colliding with a tap
        press(1'b1, 1'b1, 10);
        chk("both keys", int'(bpm), 61);
        tap_up_n = 1'b0;
        repeat (4) @(negedge clock);
        preset_sel = 5'd2;
        repeat (10) @(negedge clock);
        tap_up_n = 1'b1;
        repeat (12) @(negedge clock);
        m_sel = 2;
        m_bpm = 80;
        chk("preset beats tap", int'(bpm), 80);
        wait_idle("collide");
        chk_model("collide");

        // Randomised operations against the model
        for (int i = 0; i < 12; i++) begin
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                s = int'($urandom_range(0, 31));
                set_sel(s);
            end else begin
                press(op == 1, op == 2, 10);
                repeat (4) @(negedge clock);
                wait_idle("rand");
            end
            chk_model("rand");
            measure_step("rand", period_of(m_bpm));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
